controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/controller.sv
// rtl/controller.sv - multi-cycle instruction controller: fetch/decode FSM driving datapath selects and strobes
module controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [1:0]  alu_a_select,
  output logic        alu_b_select,
  output logic [2:0]  alu_operation,
  output logic        program_counter_write_enable,
  output logic        instruction_write_enable,
  output logic        status_write_enable,
  output logic        register_write_enable,
  output logic [1:0]  register_write_data_select,
  output logic        illegal_instruction,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH        = 3'd0,
    S_LOAD_IR      = 3'd1,
    S_INCREMENT_PC = 3'd2,
    S_DECODE       = 3'd3,
    S_EXECUTE      = 3'd4,
    S_WRITEBACK    = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_CMP   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_SHIFT = 3'd6;

  state_e state_q, state_d;

  logic [3:0] opcode, ext, code;
  logic       is_rr, is_rr_alu, is_imm_alu, is_lsh, is_alu;
  logic       is_mov, is_movi, is_lui, is_move, is_cmp, sets_status;
  logic [2:0] decoded_op;
  logic [1:0] decoded_a_sel;

  function automatic logic alu_code(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11: alu_code = 1'b1;
      default:                             alu_code = 1'b0;
    endcase
  endfunction

  // RR instructions carry their operation in ext; immediates carry it in opcode with the same encoding.
  assign opcode      = instruction[15:12];
  assign ext         = instruction[7:4];
  assign is_rr       = (opcode == 4'd0);
  assign code        = is_rr ? ext : opcode;
  assign is_rr_alu   = is_rr && alu_code(ext);
  assign is_imm_alu  = alu_code(opcode);
  assign is_lsh      = (opcode == 4'd8) && (ext == 4'd4);
  assign is_alu      = is_rr_alu || is_imm_alu || is_lsh;
  assign is_mov      = is_rr && (ext == 4'd13);
  assign is_movi     = (opcode == 4'd13);
  assign is_lui      = (opcode == 4'd15);
  assign is_move     = is_mov || is_movi || is_lui;
  assign is_cmp      = (is_rr_alu || is_imm_alu) && (code == 4'd11);
  assign sets_status = (is_rr_alu || is_imm_alu) &&
                       ((code == 4'd5) || (code == 4'd9) || (code == 4'd11));

  always_comb begin
    decoded_op = OP_ADD;
    case (code)
      4'd1:  decoded_op = OP_AND;
      4'd2:  decoded_op = OP_OR;
      4'd3:  decoded_op = OP_XOR;
      4'd5:  decoded_op = OP_ADD;
      4'd9:  decoded_op = OP_SUB;
      4'd11: decoded_op = OP_CMP;
      default: decoded_op = OP_ADD;
    endcase
    if (is_lsh) decoded_op = OP_SHIFT;
  end

  always_comb begin
    decoded_a_sel = 2'd3;
    if (is_rr || is_lsh)
      decoded_a_sel = 2'd1;
    else if ((opcode == 4'd5) || (opcode == 4'd9) || (opcode == 4'd11))
      decoded_a_sel = 2'd2;
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d                      = S_FETCH;
    alu_a_select                 = 2'd0;
    alu_b_select                 = 1'b0;
    alu_operation                = OP_ADD;
    program_counter_write_enable = 1'b0;
    instruction_write_enable     = 1'b0;
    status_write_enable          = 1'b0;
    register_write_enable        = 1'b0;
    register_write_data_select   = 2'd0;
    illegal_instruction          = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_LOAD_IR;
      S_LOAD_IR: begin
        instruction_write_enable = 1'b1;
        state_d                  = S_INCREMENT_PC;
      end
      S_INCREMENT_PC: begin
        alu_a_select                 = 2'd0;
        alu_b_select                 = 1'b1;
        alu_operation                = OP_ADD;
        program_counter_write_enable = 1'b1;
        state_d                      = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu)
          state_d = S_EXECUTE;
        else if (is_move)
          state_d = S_WRITEBACK;
        else
          illegal_instruction = 1'b1;
      end
      S_EXECUTE: begin
        if (is_alu) begin
          alu_a_select        = decoded_a_sel;
          alu_operation       = decoded_op;
          status_write_enable = sets_status;
          state_d             = is_cmp ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        register_write_enable = 1'b1;
        if (is_mov)
          register_write_data_select = 2'd1;
        else if (is_movi)
          register_write_data_select = 2'd2;
        else if (is_lui)
          register_write_data_select = 2'd3;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule
